nm_dir_sequencer: RTL

//  Sequences validator and flipper over NUM_DIRS board directions for one move.
//  NUM_DIRS is 4 (orthogonal) or 8 (adds diagonals).

---
 rtl/othello_pkg.sv | 26 ++
 rtl/nm_dir_sequencer_if.sv | 36 +++
 rtl/nm_step_lut.sv | 37 +++
 rtl/nm_dir_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/othello_pkg.sv
// Shared definitions for the move-processing datapath: direction codes,
// sequencer FSM state encodings and the default padded-board row stride.
package othello_pkg;

  typedef logic [2:0] dir_code_t;

  localparam dir_code_t DIR_U  = 3'd0;
  localparam dir_code_t DIR_D  = 3'd1;
  localparam dir_code_t DIR_L  = 3'd2;
  localparam dir_code_t DIR_R  = 3'd3;
  localparam dir_code_t DIR_UL = 3'd4;
  localparam dir_code_t DIR_UR = 3'd5;
  localparam dir_code_t DIR_DL = 3'd6;
  localparam dir_code_t DIR_DR = 3'd7;

  localparam int DEF_ROW_STRIDE = 10;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_V_LOAD = 3'd1;
  localparam logic [2:0] ST_V_WAIT = 3'd2;
  localparam logic [2:0] ST_F_SCAN = 3'd3;
  localparam logic [2:0] ST_F_LOAD = 3'd4;
  localparam logic [2:0] ST_F_WAIT = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

endpackage

// File: rtl/nm_dir_sequencer_if.sv
// Handshake bundle between the new-move sequencer and its neighbours
// (main controller, validator, flipper).
//   master : the sequencer (drives step/strobes/status, receives enable/dones)
//   slave  : the environment around it
interface nm_dir_sequencer_if #(
  parameter int NUM_DIRS = 8,
  parameter int STEP_W   = 5
);
  logic                enable;
  logic                vali_done;
  logic                vali_dir_ok;
  logic                flip_done;
  logic [STEP_W-1:0]   step_o;
  logic                step_sign_o;
  logic                ld_vali_o;
  logic                start_vali_o;
  logic                ld_flip_o;
  logic                start_flip_o;
  logic [NUM_DIRS-1:0] dir_mask_o;
  logic                mv_valid_o;
  logic                timeout_o;
  logic                nm_done_o;
  logic                busy_o;

  modport master (
    input  enable, vali_done, vali_dir_ok, flip_done,
    output step_o, step_sign_o, ld_vali_o, start_vali_o, ld_flip_o, start_flip_o,
           dir_mask_o, mv_valid_o, timeout_o, nm_done_o, busy_o
  );

  modport slave (
    output enable, vali_done, vali_dir_ok, flip_done,
    input  step_o, step_sign_o, ld_vali_o, start_vali_o, ld_flip_o, start_flip_o,
           dir_mask_o, mv_valid_o, timeout_o, nm_done_o, busy_o
  );
endinterface

// File: rtl/nm_step_lut.sv
// Direction -> cell-index step lookup for a padded board.
//   dir_i  : direction code (DIR_U..DIR_DR)
//   step_o : step magnitude
//   sign_o : 1 = subtract (toward up/left), 0 = add
module nm_step_lut
  import othello_pkg::*;
#(
  parameter int ROW_STRIDE = DEF_ROW_STRIDE,
  parameter int STEP_W     = 5
) (
  input  dir_code_t         dir_i,
  output logic [STEP_W-1:0] step_o,
  output logic              sign_o
);

  localparam logic [STEP_W-1:0] S_ROW  = STEP_W'(ROW_STRIDE);
  localparam logic [STEP_W-1:0] S_DIAG = STEP_W'(ROW_STRIDE + 1);
  localparam logic [STEP_W-1:0] S_ANTI = STEP_W'(ROW_STRIDE - 1);
  localparam logic [STEP_W-1:0] S_ONE  = STEP_W'(1);

  always_comb begin
    step_o = S_ROW;
    sign_o = 1'b1;
    case (dir_i)
      DIR_U:  begin step_o = S_ROW;  sign_o = 1'b1; end
      DIR_D:  begin step_o = S_ROW;  sign_o = 1'b0; end
      DIR_L:  begin step_o = S_ONE;  sign_o = 1'b1; end
      DIR_R:  begin step_o = S_ONE;  sign_o = 1'b0; end
      DIR_UL: begin step_o = S_DIAG; sign_o = 1'b1; end
      DIR_UR: begin step_o = S_ANTI; sign_o = 1'b1; end
      DIR_DL: begin step_o = S_ANTI; sign_o = 1'b0; end
      DIR_DR: begin step_o = S_DIAG; sign_o = 1'b0; end
      default: begin step_o = S_ROW; sign_o = 1'b1; end
    endcase
  end

endmodule

// File: rtl/nm_dir_sequencer.sv
// New-move direction sequencer: runs the validator over every direction,
// then the flipper over the directions that validated, with a watchdog on
// each wait. All outputs are registered.
//   clock, reset : system clock, synchronous active-low reset
//   bus (master) : enable / vali_done / vali_dir_ok / flip_done in;
//                  step, strobes, dir mask, move-valid, timeout, done, busy out
//
// state   | meaning
// --------+-----------------------------------------------------
// IDLE    | waiting for a new-move enable
// V_LOAD  | load+start validator for direction d (1 cycle)
// V_WAIT  | waiting for vali_done (or watchdog) for direction d
// F_SCAN  | look for the next validated direction, one per cycle
// F_LOAD  | load+start flipper for direction d (1 cycle)
// F_WAIT  | waiting for flip_done (or watchdog) for direction d
// DONE    | report completion (1 cycle)
module nm_dir_sequencer
  import othello_pkg::*;
#(
  parameter int NUM_DIRS   = 8,
  parameter int ROW_STRIDE = DEF_ROW_STRIDE,
  parameter int STEP_W     = 5,
  parameter int TIMEOUT    = 255
) (
  input  logic               clock,
  input  logic               reset,
  nm_dir_sequencer_if.master bus
);

  localparam int DIR_W = $clog2(NUM_DIRS);
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [DIR_W-1:0] LAST_DIR = DIR_W'(NUM_DIRS - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);

  logic [2:0]          state_q, state_d;
  logic [DIR_W-1:0]    dir_q, dir_d;
  logic [NUM_DIRS-1:0] mask_q, mask_d;
  logic [WD_W-1:0]     wd_q, wd_d, wd_inc;
  logic                timeout_q, timeout_d;
  logic                mv_valid_q, mv_valid_d;
  logic [STEP_W-1:0]   step_q;
  logic                sign_q;
  logic                ld_vali_q, ld_flip_q, done_q, busy_q;
  logic [STEP_W-1:0]   lut_step;
  logic                lut_sign;
  logic                last_dir, wd_expire;

  // Step is looked up for the next-cycle direction so the registered
  // step/sign line up with the LOAD strobes.
  nm_step_lut #(
    .ROW_STRIDE (ROW_STRIDE),
    .STEP_W     (STEP_W)
  ) u_step_lut (
    .dir_i  (3'(dir_d)),
    .step_o (lut_step),
    .sign_o (lut_sign)
  );

  assign last_dir = (dir_q == LAST_DIR);
  // wd_q counts completed wait cycles; expiry fires on the TIMEOUT-th one.
  assign wd_inc    = wd_q + WD_W'(1);
  assign wd_expire = (TIMEOUT != 0) && (wd_inc == WD_LIMIT);

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    mask_d     = mask_q;
    wd_d       = wd_q;
    timeout_d  = timeout_q;
    mv_valid_d = mv_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.enable) begin
          state_d    = ST_V_LOAD;
          dir_d      = '0;
          mask_d     = '0;
          timeout_d  = 1'b0;
          mv_valid_d = 1'b0;
        end
      end
      ST_V_LOAD: begin
        state_d = ST_V_WAIT;
        wd_d    = '0;
      end
      ST_V_WAIT: begin
        if (bus.vali_done || wd_expire) begin
          // A watchdog expiry counts the direction as invalid.
          mask_d[dir_q] = bus.vali_done & bus.vali_dir_ok;
          if (!bus.vali_done) timeout_d = 1'b1;
          if (last_dir) begin
            dir_d   = '0;
            state_d = ST_F_SCAN;
          end else begin
            dir_d   = dir_q + DIR_W'(1);
            state_d = ST_V_LOAD;
          end
        end else begin
          wd_d = wd_inc;
        end
      end
      ST_F_SCAN: begin
        if (mask_q[dir_q]) state_d = ST_F_LOAD;
        else if (last_dir) state_d = ST_DONE;
        else               dir_d   = dir_q + DIR_W'(1);
      end
      ST_F_LOAD: begin
        state_d = ST_F_WAIT;
        wd_d    = '0;
      end
      ST_F_WAIT: begin
        if (bus.flip_done || wd_expire) begin
          if (!bus.flip_done) timeout_d = 1'b1;
          if (last_dir) begin
            state_d = ST_DONE;
          end else begin
            dir_d   = dir_q + DIR_W'(1);
            state_d = ST_F_SCAN;
          end
        end else begin
          wd_d = wd_inc;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Move-valid is published in the same cycle as the done pulse.
    if (state_d == ST_DONE) mv_valid_d = |mask_d;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      dir_q      <= '0;
      mask_q     <= '0;
      wd_q       <= '0;
      timeout_q  <= 1'b0;
      mv_valid_q <= 1'b0;
      step_q     <= '0;
      sign_q     <= 1'b0;
      ld_vali_q  <= 1'b0;
      ld_flip_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      wd_q       <= wd_d;
      timeout_q  <= timeout_d;
      mv_valid_q <= mv_valid_d;
      ld_vali_q  <= (state_d == ST_V_LOAD);
      ld_flip_q  <= (state_d == ST_F_LOAD);
      done_q     <= (state_d == ST_DONE);
      busy_q     <= (state_d != ST_IDLE);
      // Step/sign hold between loads so they stay stable through the waits.
      if (state_d == ST_V_LOAD || state_d == ST_F_LOAD) begin
        step_q <= lut_step;
        sign_q <= lut_sign;
      end
    end
  end

  assign bus.step_o       = step_q;
  assign bus.step_sign_o  = sign_q;
  assign bus.ld_vali_o    = ld_vali_q;
  assign bus.start_vali_o = ld_vali_q;
  assign bus.ld_flip_o    = ld_flip_q;
  assign bus.start_flip_o = ld_flip_q;
  assign bus.dir_mask_o   = mask_q;
  assign bus.mv_valid_o   = mv_valid_q;
  assign bus.timeout_o    = timeout_q;
  assign bus.nm_done_o    = done_q;
  assign bus.busy_o       = busy_q;

endmodule
